// File: rtl/ulpi_reg_read.sv
`default_nettype none
// ============================================================================
// Module   : ulpi_reg_read
// Purpose  : ULPI register read sequencer (TXCMD, turnaround, capture) with
//            bounded retry on PHY aborts and turnaround timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ulpi_reg_read #(
   parameter logic [1:0]  REG_READ_CMD = 2'b11,
   parameter int unsigned RETRY_LIMIT  = 3,
   parameter int unsigned TA_TIMEOUT   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       READ_DATA,
   input  logic [5:0] ADDR,
   output logic [7:0] DATA,
   output logic       DATA_VALID,
   output logic       ERROR,
   output logic       BUSY,
   input  logic       DIR,
   output logic       STP,
   input  logic       NXT,
   input  logic [7:0] ULPI_DATA_IN,
   output logic [7:0] ULPI_DATA_OUT
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_TXCMD      = 3'd1,
      S_TURNAROUND = 3'd2,
      S_READ       = 3'd3,
      S_RELEASE    = 3'd4,
      S_ABORT_WAIT = 3'd5
   } state_t;

   localparam logic [3:0] c_retry_limit = 4'(RETRY_LIMIT);
   localparam logic [3:0] c_ta_timeout  = 4'(TA_TIMEOUT);

   state_t     r_state;
   logic [5:0] r_addr;
   logic [3:0] r_retry;
   logic [3:0] r_ta;
   logic [7:0] r_data;
   logic       r_valid;
   logic       r_error;
   logic       r_stp;
   logic [7:0] r_out;
   logic [3:0] w_ta_next;

   assign w_ta_next = r_ta + 4'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_retry <= '0;
         r_ta    <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_error <= 1'b0;
         r_stp   <= 1'b0;
         r_out   <= '0;
      end else begin
         r_valid <= 1'b0;
         r_error <= 1'b0;
         r_stp   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (READ_DATA && !DIR) begin
                  r_addr  <= ADDR;
                  r_out   <= {REG_READ_CMD, ADDR};
                  r_retry <= '0;
                  r_state <= S_TXCMD;
               end
            end
            // DIR outranks NXT: a PHY turnaround always wins over our TXCMD
            S_TXCMD: begin
               if (DIR) begin
                  r_out   <= '0;
                  r_state <= S_ABORT_WAIT;
               end else if (NXT) begin
                  r_out   <= '0;
                  r_ta    <= '0;
                  r_state <= S_TURNAROUND;
               end
            end
            S_TURNAROUND: begin
               if (DIR) begin
                  r_state <= NXT ? S_ABORT_WAIT : S_READ;
               end else begin
                  r_ta <= w_ta_next;
                  if (w_ta_next == c_ta_timeout) begin
                     r_error <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
            end
            S_READ: begin
               if (DIR && !NXT) begin
                  r_data  <= ULPI_DATA_IN;
                  r_valid <= 1'b1;
                  r_state <= S_RELEASE;
               end else begin
                  r_state <= S_ABORT_WAIT;
               end
            end
            S_RELEASE: begin
               if (!DIR) r_state <= S_IDLE;
            end
            S_ABORT_WAIT: begin
               if (!DIR) begin
                  if (r_retry < c_retry_limit) begin
                     r_retry <= r_retry + 4'd1;
                     r_out   <= {REG_READ_CMD, r_addr};
                     r_state <= S_TXCMD;
                  end else begin
                     r_error <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_data  <= '0;
               r_out   <= '0;
            end
         endcase
      end
   end

   assign DATA          = r_data;
   assign DATA_VALID    = r_valid;
   assign ERROR         = r_error;
   assign STP           = r_stp;
   assign ULPI_DATA_OUT = r_out;
   assign BUSY          = (r_state != S_IDLE);

endmodule
`default_nettype wire
